// File: rtl/alu_seq_if.sv
// alu_seq request/response bundle.
// master drives requests, slave returns results and flags.
interface alu_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [4:0]       ALUOp;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Y;
  logic             z;
  logic             v;
  logic             n;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, ALUOp, A, B,
    input  Y, z, v, n, busy, done, err
  );

  modport slave (
    input  start, ALUOp, A, B,
    output Y, z, v, n, busy, done, err
  );
endinterface

// File: rtl/alu_seq.sv
// Registered execute-stage ALU.
// Single-cycle ops finish in one clock; mul/div iterate one bit per clock.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0]   LAST = SHW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  localparam logic [4:0] OP_AND   = 5'b00000;
  localparam logic [4:0] OP_OR    = 5'b00001;
  localparam logic [4:0] OP_XOR   = 5'b00010;
  localparam logic [4:0] OP_NOR   = 5'b00011;
  localparam logic [4:0] OP_ADD   = 5'b01000;
  localparam logic [4:0] OP_SUB   = 5'b01001;
  localparam logic [4:0] OP_SLT   = 5'b01010;
  localparam logic [4:0] OP_SLTU  = 5'b01011;
  localparam logic [4:0] OP_SLL   = 5'b10000;
  localparam logic [4:0] OP_SRL   = 5'b10001;
  localparam logic [4:0] OP_SRA   = 5'b10010;
  localparam logic [4:0] OP_MUL   = 5'b11000;
  localparam logic [4:0] OP_MULHU = 5'b11001;
  localparam logic [4:0] OP_DIVU  = 5'b11010;
  localparam logic [4:0] OP_REMU  = 5'b11011;

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               z_q, z_d;
  logic               v_q, v_d;
  logic               n_q, n_d;
  logic               err_q, err_d;
  logic               done_q, done_d;

  logic               is_mul, is_div, div_zero, go_iter;
  logic [WIDTH-1:0]   sc_y;
  logic               sc_v, sc_err;
  logic [WIDTH-1:0]   sum, b_neg, diff;
  logic [SHW-1:0]     sh;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH:0]     rem_sh, trial;
  logic [WIDTH-1:0]   res_iter;

  assign is_mul   = (bus.ALUOp == OP_MUL) || (bus.ALUOp == OP_MULHU);
  assign is_div   = (bus.ALUOp == OP_DIVU) || (bus.ALUOp == OP_REMU);
  assign div_zero = is_div && (bus.B == '0);
  assign go_iter  = is_mul || (is_div && !div_zero);

  // Single-cycle result, overflow and error straight from the request.
  always_comb begin
    sum    = bus.A + bus.B;
    b_neg  = ~bus.B + ONE;
    diff   = bus.A + b_neg;
    sh     = bus.B[SHW-1:0];
    sc_y   = '0;
    sc_v   = 1'b0;
    sc_err = 1'b0;
    unique case (bus.ALUOp)
      OP_AND:  sc_y = bus.A & bus.B;
      OP_OR:   sc_y = bus.A | bus.B;
      OP_XOR:  sc_y = bus.A ^ bus.B;
      OP_NOR:  sc_y = ~(bus.A | bus.B);
      OP_ADD: begin
        sc_y = sum;
        sc_v = (bus.A[WIDTH-1] == bus.B[WIDTH-1])
            && (sum[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_y = diff;
        sc_v = (bus.A[WIDTH-1] == b_neg[WIDTH-1])
            && (diff[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SLT:
        sc_y = {{(WIDTH-1){1'b0}},
                $signed(bus.A) < $signed(bus.B)};
      OP_SLTU:
        sc_y = {{(WIDTH-1){1'b0}}, bus.A < bus.B};
      OP_SLL:  sc_y = bus.A << sh;
      OP_SRL:  sc_y = bus.A >> sh;
      OP_SRA:  sc_y = $unsigned($signed(bus.A) >>> sh);
      OP_MUL, OP_MULHU: sc_y = '0;
      OP_DIVU: begin
        sc_y   = div_zero ? '1 : '0;
        sc_err = div_zero;
      end
      OP_REMU: begin
        sc_y   = div_zero ? bus.A : '0;
        sc_err = div_zero;
      end
      default: sc_err = 1'b1;
    endcase
  end

  // One shift-add or restoring subtract-shift step on the accumulator.
  always_comb begin
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    trial    = rem_sh - {1'b0, b_q};
    acc_step = {acc_q[2*WIDTH-2:0], 1'b0}
             + (b_q[WIDTH-1] ? {{WIDTH{1'b0}}, a_q} : '0);
    if (sel_q[1]) begin
      if (!trial[WIDTH])
        acc_step = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else
        acc_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
    res_iter = sel_q[0] ? acc_step[2*WIDTH-1:WIDTH]
                        : acc_step[WIDTH-1:0];
  end

  // Next state: iterate for WIDTH steps, otherwise stay idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start && go_iter) state_d = RUN;
      RUN:  if (cnt_q == LAST)        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: capture, iterate and publish results.
  always_comb begin
    sel_d  = sel_q;
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    y_d    = y_q;
    z_d    = z_q;
    v_d    = v_q;
    n_d    = n_q;
    err_d  = err_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sel_d = bus.ALUOp[1:0];
          a_d   = bus.A;
          b_d   = bus.B;
          if (go_iter) begin
            acc_d = '0;
            cnt_d = '0;
          end else begin
            y_d    = sc_y;
            z_d    = (sc_y == '0);
            v_d    = sc_v;
            n_d    = sc_y[WIDTH-1];
            err_d  = sc_err;
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + SHW'(1);
        if (sel_q[1]) a_d = {a_q[WIDTH-2:0], 1'b0};
        else          b_d = {b_q[WIDTH-2:0], 1'b0};
        if (cnt_q == LAST) begin
          y_d    = res_iter;
          z_d    = (res_iter == '0);
          v_d    = 1'b0;
          n_d    = res_iter[WIDTH-1];
          err_d  = 1'b0;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      y_q    <= '0;
      z_q    <= 1'b0;
      v_q    <= 1'b0;
      n_q    <= 1'b0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      y_q    <= y_d;
      z_q    <= z_d;
      v_q    <= v_d;
      n_q    <= n_d;
      err_q  <= err_d;
      done_q <= done_d;
    end
  end

  // Outputs are registered values; busy while iterating.
  always_comb begin
    bus.Y    = y_q;
    bus.z    = z_q;
    bus.v    = v_q;
    bus.n    = n_q;
    bus.err  = err_q;
    bus.done = done_q;
    bus.busy = (state_q == RUN);
  end
endmodule

// File: tb/tb_alu_seq.sv
// Randomised scoreboard bench for alu_seq at WIDTH=32 and WIDTH=8.
// Expected results come from a plain-arithmetic reference model.
module tb_alu_seq;
  typedef struct {
    longint unsigned y;
    bit z, v, n, err, iter;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(32)) bus32 ();
  alu_seq_if #(.WIDTH(8))  bus8 ();

  alu_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

  exp_t q32[$];
  exp_t q8[$];
  exp_t e32, e8;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int bc32 = 0, bc8 = 0;
  int dn32 = 0, dn8 = 0;

  bit [4:0] legal [15] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h08,
                           5'h09, 5'h0A, 5'h0B, 5'h10, 5'h11,
                           5'h12, 5'h18, 5'h19, 5'h1A, 5'h1B};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(bit [4:0] op, longint unsigned a,
                                 longint unsigned b, int w);
    exp_t e;
    longint unsigned m, s, bp;
    longint sa, sb, t;
    int sh;
    m = (64'd1 << w) - 1;
    s = 64'd1 << (w - 1);
    a = a & m;
    b = b & m;
    sa = (a & s) != 0 ? longint'(a) - longint'(m) - 1 : longint'(a);
    sb = (b & s) != 0 ? longint'(b) - longint'(m) - 1 : longint'(b);
    sh = int'(b % longint'(w));
    e.y = 0; e.v = 0; e.err = 0; e.iter = 0; e.due = 0;
    case (op)
      5'h00: e.y = a & b;
      5'h01: e.y = a | b;
      5'h02: e.y = a ^ b;
      5'h03: e.y = ~(a | b) & m;
      5'h08: begin
        e.y = (a + b) & m;
        e.v = ((a & s) == (b & s)) && ((e.y & s) != (a & s));
      end
      5'h09: begin
        bp  = (~b + 1) & m;
        e.y = (a - b) & m;
        e.v = ((a & s) == (bp & s)) && ((e.y & s) != (a & s));
      end
      5'h0A: e.y = (sa < sb) ? 1 : 0;
      5'h0B: e.y = (a < b) ? 1 : 0;
      5'h10: e.y = (a << sh) & m;
      5'h11: e.y = a >> sh;
      5'h12: begin
        t   = sa >>> sh;
        e.y = t & m;
      end
      5'h18: begin e.y = (a * b) & m; e.iter = 1; end
      5'h19: begin e.y = (a * b) >> w; e.iter = 1; end
      5'h1A: if (b == 0) begin e.y = m; e.err = 1; end
             else begin e.y = a / b; e.iter = 1; end
      5'h1B: if (b == 0) begin e.y = a; e.err = 1; end
             else begin e.y = a % b; e.iter = 1; end
      default: begin e.y = 0; e.err = 1; end
    endcase
    e.z = (e.y == 0);
    e.n = (e.y & s) != 0;
    return e;
  endfunction

  task automatic chk(string t, string nm, longint unsigned act,
                     longint unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s %s: got %0h expected %0h", t, nm, act, exp);
    end
  endtask

  task automatic cmp(string t, exp_t e, longint unsigned y,
                     bit z, bit v, bit n, bit err, int bc, int w);
    chk(t, "Y", y, e.y);
    chk(t, "z", z, e.z);
    chk(t, "v", v, e.v);
    chk(t, "n", n, e.n);
    chk(t, "err", err, e.err);
    chk(t, "done_cycle", cyc, e.due);
    chk(t, "busy_cycles", bc, e.iter ? w : 0);
  endtask

  // Monitor for the 32-bit instance.
  always @(negedge clk) begin
    if (reset) bc32 = 0;
    else begin
      if (bus32.busy) bc32++;
      if (bus32.done) begin
        dn32++;
        if (q32.size() == 0) begin
          tests++; fails++;
          $display("FAIL w32 unexpected_done: got done=1 expected 0");
        end else begin
          e32 = q32.pop_front();
          cmp("w32", e32, bus32.Y, bus32.z, bus32.v, bus32.n,
              bus32.err, bc32, 32);
        end
        bc32 = 0;
      end
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (reset) bc8 = 0;
    else begin
      if (bus8.busy) bc8++;
      if (bus8.done) begin
        dn8++;
        if (q8.size() == 0) begin
          tests++; fails++;
          $display("FAIL w8 unexpected_done: got done=1 expected 0");
        end else begin
          e8 = q8.pop_front();
          cmp("w8", e8, bus8.Y, bus8.z, bus8.v, bus8.n,
              bus8.err, bc8, 8);
        end
        bc8 = 0;
      end
    end
  end

  task automatic issue32(bit [4:0] op, logic [31:0] a, logic [31:0] b);
    exp_t e;
    int g = 0;
    while (bus32.busy) begin
      if ($urandom_range(3) == 0) begin
        bus32.start = 1'b1;
        bus32.ALUOp = 5'($urandom);
        bus32.A = $urandom;
        bus32.B = $urandom;
      end else bus32.start = 1'b0;
      @(posedge clk); #1;
      g++;
      if (g > 200) begin
        tests++; fails++;
        $display("FAIL w32 busy_timeout: got busy=1 expected 0");
        break;
      end
    end
    bus32.start = 1'b1;
    bus32.ALUOp = op;
    bus32.A = a;
    bus32.B = b;
    e = model(op, a, b, 32);
    e.due = cyc + 1 + (e.iter ? 32 : 0);
    q32.push_back(e);
    @(posedge clk); #1;
    bus32.start = 1'b0;
  endtask

  task automatic issue8(bit [4:0] op, logic [7:0] a, logic [7:0] b);
    exp_t e;
    int g = 0;
    while (bus8.busy) begin
      if ($urandom_range(3) == 0) begin
        bus8.start = 1'b1;
        bus8.ALUOp = 5'($urandom);
        bus8.A = 8'($urandom);
        bus8.B = 8'($urandom);
      end else bus8.start = 1'b0;
      @(posedge clk); #1;
      g++;
      if (g > 200) begin
        tests++; fails++;
        $display("FAIL w8 busy_timeout: got busy=1 expected 0");
        break;
      end
    end
    bus8.start = 1'b1;
    bus8.ALUOp = op;
    bus8.A = a;
    bus8.B = b;
    e = model(op, a, b, 8);
    e.due = cyc + 1 + (e.iter ? 8 : 0);
    q8.push_back(e);
    @(posedge clk); #1;
    bus8.start = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((q32.size() != 0 || q8.size() != 0) && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    chk("all", "pending_after_drain", q32.size() + q8.size(), 0);
  endtask

  function automatic bit [4:0] rand_op();
    if ($urandom_range(19) == 0) return 5'($urandom);
    return legal[$urandom_range(14)];
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(5))
      0: return 32'd0;
      1: return 32'($urandom_range(40));
      2: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int d32;
    bus32.start = 1'b0; bus32.ALUOp = '0; bus32.A = '0; bus32.B = '0;
    bus8.start = 1'b0;  bus8.ALUOp = '0;  bus8.A = '0;  bus8.B = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst", "Y", bus32.Y, 0);
    chk("rst", "z", bus32.z, 0);
    chk("rst", "v", bus32.v, 0);
    chk("rst", "n", bus32.n, 0);
    chk("rst", "busy", bus32.busy, 0);
    chk("rst", "done", bus32.done, 0);
    chk("rst", "err", bus32.err, 0);
    chk("rst", "Y8", bus8.Y, 0);
    @(posedge clk); #1;

    issue32(5'h08, 32'h7FFF_FFFF, 32'h1);
    issue32(5'h09, 32'd5, 32'd5);
    issue32(5'h0A, 32'hFFFF_FFFF, 32'd1);
    issue32(5'h0B, 32'hFFFF_FFFF, 32'd1);
    issue32(5'h12, 32'h8000_0000, 32'd4);
    issue32(5'h10, 32'd1, 32'd33);
    issue32(5'h03, 32'd0, 32'd0);
    issue32(5'h18, 32'hFFFF_FFFF, 32'd2);
    issue32(5'h19, 32'hFFFF_FFFF, 32'd2);
    issue32(5'h1A, 32'd100, 32'd7);
    issue32(5'h1B, 32'd100, 32'd7);
    issue32(5'h1A, 32'd100, 32'd0);
    issue32(5'h1B, 32'd100, 32'd0);
    issue32(5'h04, 32'd3, 32'd9);
    issue32(5'h09, 32'h8000_0000, 32'd1);

    for (int i = 0; i < 250; i++)
      issue32(rand_op(), rand_val(), rand_val());
    drain();

    issue8(5'h08, 8'h7F, 8'h01);
    issue8(5'h1A, 8'd200, 8'd3);
    issue8(5'h1B, 8'd200, 8'd3);
    issue8(5'h19, 8'hFF, 8'hFF);
    issue8(5'h1A, 8'd5, 8'd0);
    for (int i = 0; i < 60; i++)
      issue8(rand_op(), 8'($urandom), 8'($urandom_range(255)));
    drain();

    issue32(5'h18, $urandom, $urandom);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    q32.delete();
    q8.delete();
    d32 = dn32;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort", "busy", bus32.busy, 0);
    chk("abort", "done", bus32.done, 0);
    chk("abort", "Y", bus32.Y, 0);
    chk("abort", "flags", {bus32.z, bus32.v, bus32.n, bus32.err}, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("abort", "late_done_count", dn32 - d32, 0);

    issue32(5'h1A, 32'd77, 32'd7);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the combinational 32-bit datapath ALU.
- Registers every result and adds iterative multiply/divide operations, a start/busy/done handshake and an error flag.
- Sits in the execute stage. The pipeline control stalls on busy and consumes Y/flags when done pulses.
- Single-cycle ops (bool, arith, compare, shift) complete in 1 clock. MUL/DIV ops take WIDTH+1 clocks.

Parameters:
- WIDTH, 32, datapath width. Must be a power of 2 and at least 8.
- SHW, $clog2(WIDTH), derived shift-amount width. Not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while busy=0
- ALUOp  input  5  operation select, captured with start
- A  input  WIDTH  operand A, captured with start
- B  input  WIDTH  operand B, captured with start
- Y  output  WIDTH  registered result
- z  output  1  registered: Y == 0
- v  output  1  registered: signed overflow (ADD/SUB only, else 0)
- n  output  1  registered: Y[WIDTH-1]
- busy  output  1  high while an iterative op is running
- done  output  1  one-cycle pulse; Y/z/v/n/err are valid from this cycle
- err  output  1  registered: illegal ALUOp, or divide by zero

Behaviour:
- Clocking/reset: one clock, clk. reset is synchronous, active-high. Reset priority is above all else.
- On reset: Y=0, z=0, v=0, n=0, busy=0, done=0, err=0, state=IDLE.
- Reset mid-operation aborts the op; no done is produced for it.
- ALUOp encoding (any other value is illegal):
  - 00000 AND, 00001 OR, 00010 XOR, 00011 NOR
  - 01000 ADD, 01001 SUB
  - 01010 SLT (signed A<B → 1 else 0), 01011 SLTU (unsigned)
  - 10000 SLL, 10001 SRL, 10010 SRA; shift amount = B[SHW-1:0], upper B bits ignored
  - 11000 MUL (low WIDTH bits of unsigned A*B), 11001 MULHU (high WIDTH bits)
  - 11010 DIVU (unsigned quotient), 11011 REMU (unsigned remainder)
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH.
  - v = (A[W-1]==B'[W-1]) && (Y[W-1]!=A[W-1]), where B' = B for ADD and ~B+1 for SUB.
- FSM states: IDLE, RUN.
- IDLE, start=1, single-cycle op (including illegal op or divide by zero):
  - Result, flags and err are registered at that edge.
  - done=1 in the next cycle. State stays IDLE.
- IDLE, start=1, MUL/MULHU/DIVU/REMU with valid divisor:
  - Latch operands, clear the 2*WIDTH accumulator, counter=0, go to RUN.
- RUN: one shift-add (multiply) or restoring subtract-shift (divide) step per cycle.
  - After WIDTH steps: register the result, done=1, return to IDLE.
  - busy=1 for exactly WIDTH cycles. done is asserted WIDTH+1 cycles after the start edge.
- start while busy=1 is ignored. The in-flight operands and ALUOp are unaffected.
- start in the same cycle as done is accepted, giving back-to-back ops with no bubble.
- Divide by zero (DIVU/REMU with B=0):
  - No iteration; treated as single-cycle.
  - DIVU result = all ones; REMU result = A; err=1.
- Illegal ALUOp: Y=0, z=1, v=0, n=0, err=1, single-cycle.
- Flags for non-ADD/SUB ops: z and n are derived from Y; v=0.
- err=0 for every legal, non-faulting op.
- Outputs hold between operations: Y, z, v, n and err keep their values until the next done. done is low otherwise.

Test Plan:
- WIDTH=32, ADD, A=0x7FFFFFFF, B=0x00000001 → next cycle: done=1, Y=0x80000000, v=1, n=1, z=0, err=0, busy=0.
- SUB, A=5, B=5 → Y=0, z=1, v=0. SLT A=0xFFFFFFFF, B=1 → Y=1. SLTU with the same operands → Y=0.
- SRA A=0x80000000, B=4 → Y=0xF8000000. SLL A=1, B=33 → Y=0x00000002 (amount = B[4:0] = 1). NOR A=0, B=0 → Y=0xFFFFFFFF.
- MUL A=0xFFFFFFFF, B=2 → Y=0xFFFFFFFE. MULHU with the same operands → Y=1.
  - busy high for exactly 32 cycles; done 33 cycles after the start edge.
  - A start pulse mid-run changes nothing.
  - A new start in the done cycle is accepted.
- DIVU A=100, B=7 → Y=14. REMU with the same operands → Y=2.
  - DIVU B=0 → Y=0xFFFFFFFF, err=1, done 1 cycle after start, busy never asserted.
- Reset at cycle 10 of a MUL → next cycle: busy=0, done=0, Y=0, all flags 0; no later done for the aborted op.
  - Illegal ALUOp 00100 → Y=0, z=1, err=1.
  - WIDTH=8 instance: ADD 0x7F+0x01 → Y=0x80, v=1; DIVU 200/3 → Y=66 with done after 9 cycles.
